// File: rtl/reg_writeback_if.sv
// Producer/consumer bundle for reg_writeback: ALU and load result ports,
// register-file write port and the two forwarding lookup ports.
interface reg_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              reg_write;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    logic [ADDR_W-1:0] q1_addr;
    logic [ADDR_W-1:0] q2_addr;
    logic              q1_hit;
    logic              q2_hit;
    logic [DATA_W-1:0] q1_data;
    logic [DATA_W-1:0] q2_data;

    logic              busy;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        output reg_write, write_addr, write_data,
        input  q1_addr, q2_addr,
        output q1_hit, q2_hit, q1_data, q2_data,
        output busy
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        input  reg_write, write_addr, write_data,
        output q1_addr, q2_addr,
        input  q1_hit, q2_hit, q1_data, q2_data,
        input  busy
    );
endinterface

// File: rtl/reg_writeback.sv
// In-order writeback queue: merges ALU and load results, drives the register
// file write port one entry per cycle and forwards pending values to decode.
module reg_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input  logic            clk,
    input  logic            reset,
    reg_writeback_if.slave  wb
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              ready_reg;
    logic              reg_write_reg;
    logic [ADDR_W-1:0] write_addr_reg;
    logic [DATA_W-1:0] write_data_reg;

    logic              alu_fire;
    logic              mem_fire;
    logic              deq;
    logic [1:0]        enq_n;
    logic [CNT_W-1:0]  count_next;
    logic              ready_next;
    logic [PTR_W-1:0]  alu_slot;

    // Ready guarantees two free slots, so both ports may fire on any edge.
    assign alu_fire   = wb.alu_valid & ready_reg;
    assign mem_fire   = wb.mem_valid & ready_reg;
    assign deq        = (count_reg != '0);
    assign enq_n      = {1'b0, alu_fire} + {1'b0, mem_fire};
    assign count_next = count_reg + CNT_W'(enq_n) - CNT_W'(deq);
    assign ready_next = (count_next <= CNT_W'(DEPTH - 2));
    // The load is the older instruction and takes the first slot.
    assign alu_slot   = mem_fire ? tail_reg + PTR_W'(1) : tail_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg       <= '0;
            tail_reg       <= '0;
            count_reg      <= '0;
            ready_reg      <= 1'b1;
            reg_write_reg  <= 1'b0;
            write_addr_reg <= '0;
            write_data_reg <= '0;
        end else begin
            count_reg <= count_next;
            ready_reg <= ready_next;
            tail_reg  <= tail_reg + PTR_W'(enq_n);
            if (deq) begin
                head_reg       <= head_reg + PTR_W'(1);
                reg_write_reg  <= 1'b1;
                write_addr_reg <= addr_mem[head_reg];
                write_data_reg <= data_mem[head_reg];
            end else begin
                reg_write_reg  <= 1'b0;
            end
        end
    end

    // Storage needs no reset: entries outside [head, head+count) are never read.
    always_ff @(posedge clk) begin
        if (mem_fire) begin
            addr_mem[tail_reg] <= wb.mem_addr;
            data_mem[tail_reg] <= wb.mem_data;
        end
        if (alu_fire) begin
            addr_mem[alu_slot] <= wb.alu_addr;
            data_mem[alu_slot] <= wb.alu_data;
        end
    end

    // Forwarding: write stage first, then queue oldest to youngest so the
    // youngest match overrides everything older.
    for (genvar gi = 0; gi < 2; gi++) begin : g_q
        logic [ADDR_W-1:0] qa;
        logic              hit;
        logic [DATA_W-1:0] data;

        assign qa = (gi == 0) ? wb.q1_addr : wb.q2_addr;

        always_comb begin
            logic [PTR_W-1:0] idx;
            hit  = 1'b0;
            data = '0;
            idx  = '0;
            if (reg_write_reg && (write_addr_reg == qa)) begin
                hit  = 1'b1;
                data = write_data_reg;
            end
            for (int i = DEPTH - 1; i >= 0; i--) begin
                idx = tail_reg - PTR_W'(i) - PTR_W'(1);
                if ((CNT_W'(i) < count_reg) && (addr_mem[idx] == qa)) begin
                    hit  = 1'b1;
                    data = data_mem[idx];
                end
            end
        end
    end

    assign wb.alu_ready  = ready_reg;
    assign wb.mem_ready  = ready_reg;
    assign wb.reg_write  = reg_write_reg;
    assign wb.write_addr = write_addr_reg;
    assign wb.write_data = write_data_reg;
    assign wb.q1_hit     = g_q[0].hit;
    assign wb.q1_data    = g_q[0].data;
    assign wb.q2_hit     = g_q[1].hit;
    assign wb.q2_data    = g_q[1].data;
    assign wb.busy       = (count_reg != '0) || reg_write_reg;
endmodule

// File: tb/tb_reg_writeback.sv
// Scoreboard bench for reg_writeback: queue-based reference model, directed
// scenarios followed by randomized traffic with backpressure and forwarding.
module tb_reg_writeback;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    reg_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

    reg_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (wb)
    );

    always #5 clk = ~clk;

    // Reference model: pending results in acceptance order plus the write stage.
    wr_t               pend[$];
    wr_t               sb[$];
    logic              m_wr = 1'b0;
    logic [ADDR_W-1:0] m_waddr = '0;
    logic [DATA_W-1:0] m_wdata = '0;
    logic              m_ready = 1'b1;
    logic              alu_acc_last = 1'b0;
    logic              mem_acc_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void fwd(input logic [ADDR_W-1:0] a, output logic h, output logic [DATA_W-1:0] d);
        h = 1'b0;
        d = '0;
        if (m_wr && m_waddr == a) begin
            h = 1'b1;
            d = m_wdata;
        end
        foreach (pend[i]) begin
            if (pend[i].addr == a) begin
                h = 1'b1;
                d = pend[i].data;
            end
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend.delete();
            sb.delete();
            m_wr    = 1'b0;
            m_waddr = '0;
            m_wdata = '0;
            m_ready = 1'b1;
            alu_acc_last = 1'b0;
            mem_acc_last = 1'b0;
        end else begin
            logic aacc, macc;
            wr_t  e;
            aacc = wb.alu_valid && m_ready;
            macc = wb.mem_valid && m_ready;
            if (pend.size() > 0) begin
                e = pend.pop_front();
                m_wr = 1'b1;
                m_waddr = e.addr;
                m_wdata = e.data;
            end else begin
                m_wr = 1'b0;
            end
            if (macc) begin
                e = '{addr: wb.mem_addr, data: wb.mem_data};
                pend.push_back(e);
                sb.push_back(e);
            end
            if (aacc) begin
                e = '{addr: wb.alu_addr, data: wb.alu_data};
                pend.push_back(e);
                sb.push_back(e);
            end
            m_ready = (DEPTH - pend.size()) >= 2;
            alu_acc_last = aacc;
            mem_acc_last = macc;
        end
    end

    // Monitor: compares every observable output each cycle, pops the
    // scoreboard whenever the DUT presents a register-file write.
    always @(negedge clk) begin
        if (reset) begin
            logic              h;
            logic [DATA_W-1:0] d;
            wr_t               e;
            chk("reg_write", wb.reg_write, m_wr);
            chk("alu_ready", wb.alu_ready, m_ready);
            chk("mem_ready", wb.mem_ready, m_ready);
            chk("busy", wb.busy, (pend.size() > 0) || m_wr);
            fwd(wb.q1_addr, h, d);
            chk("q1_hit", wb.q1_hit, h);
            chk("q1_data", wb.q1_data, d);
            fwd(wb.q2_addr, h, d);
            chk("q2_hit", wb.q2_hit, h);
            chk("q2_data", wb.q2_data, d);
            if (wb.reg_write) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got r%0d=%h expected no write at %0t",
                             wb.write_addr, wb.write_data, $time);
                end else begin
                    e = sb.pop_front();
                    $display("write r%0d = %h", wb.write_addr, wb.write_data);
                    chk("write_addr", wb.write_addr, e.addr);
                    chk("write_data", wb.write_data, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb.alu_valid = 1'b0;
        wb.mem_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && (pend.size() > 0 || m_wr); i++) step();
        chk("drain_bound", (pend.size() > 0) || m_wr, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        wb.alu_valid = 1'b0; wb.alu_addr = '0; wb.alu_data = '0;
        wb.mem_valid = 1'b0; wb.mem_addr = '0; wb.mem_data = '0;
        wb.q1_addr = '0; wb.q2_addr = '0;
        repeat (2) step();

        // Reset state
        chk("rst_reg_write", wb.reg_write, 1'b0);
        chk("rst_busy", wb.busy, 1'b0);
        chk("rst_alu_ready", wb.alu_ready, 1'b1);
        chk("rst_mem_ready", wb.mem_ready, 1'b1);
        chk("rst_write_addr", wb.write_addr, 0);
        chk("rst_write_data", wb.write_data, 0);
        chk("rst_q1_hit", wb.q1_hit, 1'b0);
        reset = 1'b1;

        // Single ALU result, two-edge latency
        wb.alu_valid = 1'b1; wb.alu_addr = 3; wb.alu_data = 16'h1234;
        step();
        idle_inputs();
        step();
        chk("t1_we", wb.reg_write, 1'b1);
        chk("t1_addr", wb.write_addr, 3);
        chk("t1_data", wb.write_data, 16'h1234);
        step();
        chk("t1_we_off", wb.reg_write, 1'b0);
        drain();

        // Simultaneous mem + alu to the same register
        wb.mem_valid = 1'b1; wb.mem_addr = 5; wb.mem_data = 16'hAAAA;
        wb.alu_valid = 1'b1; wb.alu_addr = 5; wb.alu_data = 16'hBBBB;
        wb.q1_addr = 5;
        step();
        idle_inputs();
        chk("t2_q1_hit", wb.q1_hit, 1'b1);
        chk("t2_q1_data", wb.q1_data, 16'hBBBB);
        step();
        chk("t2_first_data", wb.write_data, 16'hAAAA);
        step();
        chk("t2_second_data", wb.write_data, 16'hBBBB);
        drain();

        // Forwarding from the write stage, and a miss
        wb.alu_valid = 1'b1; wb.alu_addr = 2; wb.alu_data = 16'h0F0F;
        wb.q2_addr = 2; wb.q1_addr = 7;
        step();
        idle_inputs();
        step();
        chk("t4_we", wb.reg_write, 1'b1);
        chk("t4_q2_hit", wb.q2_hit, 1'b1);
        chk("t4_q2_data", wb.q2_data, 16'h0F0F);
        chk("t4_q1_hit", wb.q1_hit, 1'b0);
        chk("t4_q1_data", wb.q1_data, 0);
        step();
        chk("t4_q2_hit_after", wb.q2_hit, 1'b0);
        drain();

        // Pointer wrap: 12 results, data = index
        for (int i = 0; i < 12; i++) begin
            wb.alu_valid = 1'b1;
            wb.alu_addr  = ADDR_W'(i % 8);
            wb.alu_data  = DATA_W'(i);
            step();
        end
        idle_inputs();
        drain();

        // Backpressure: both ports valid every cycle, holding until accepted
        wb.mem_valid = 1'b1; wb.mem_addr = ADDR_W'($urandom); wb.mem_data = DATA_W'($urandom);
        wb.alu_valid = 1'b1; wb.alu_addr = ADDR_W'($urandom); wb.alu_data = DATA_W'($urandom);
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_acc_last) begin
                wb.mem_addr = ADDR_W'($urandom); wb.mem_data = DATA_W'($urandom);
            end
            if (alu_acc_last) begin
                wb.alu_addr = ADDR_W'($urandom); wb.alu_data = DATA_W'($urandom);
            end
            wb.q1_addr = ADDR_W'($urandom);
            wb.q2_addr = ADDR_W'($urandom);
        end
        idle_inputs();
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            if (!(wb.alu_valid && !alu_acc_last)) begin
                wb.alu_valid = 1'($urandom_range(0, 1));
                wb.alu_addr  = ADDR_W'($urandom);
                wb.alu_data  = DATA_W'($urandom);
            end
            if (!(wb.mem_valid && !mem_acc_last)) begin
                wb.mem_valid = 1'($urandom_range(0, 1));
                wb.mem_addr  = ADDR_W'($urandom);
                wb.mem_data  = DATA_W'($urandom);
            end
            wb.q1_addr = ADDR_W'($urandom);
            wb.q2_addr = ADDR_W'($urandom);
            step();
        end
        idle_inputs();
        drain();

        // Asynchronous reset with three entries pending
        wb.mem_valid = 1'b1; wb.mem_addr = 1; wb.mem_data = 16'h1111;
        wb.alu_valid = 1'b1; wb.alu_addr = 2; wb.alu_data = 16'h2222;
        step();
        wb.mem_addr = 3; wb.mem_data = 16'h3333;
        wb.alu_addr = 4; wb.alu_data = 16'h4444;
        step();
        idle_inputs();
        chk("t6_busy_before", wb.busy, 1'b1);
        chk("t6_ready_before", wb.alu_ready, 1'b0);
        #1 reset = 1'b0;
        #1;
        chk("t6_rst_we", wb.reg_write, 1'b0);
        chk("t6_rst_busy", wb.busy, 1'b0);
        chk("t6_rst_alu_ready", wb.alu_ready, 1'b1);
        chk("t6_rst_mem_ready", wb.mem_ready, 1'b1);
        #1 reset = 1'b1;
        repeat (6) step();
        chk("t6_no_stale_busy", wb.busy, 1'b0);

        drain();
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-side companion to the 8×16 register file: accepts results from the ALU and memory stages, queues them in a small in-order buffer, and drives the register file's single write port, one write per cycle. It also answers forwarding lookups for results that are accepted but not yet written, so decode-stage reads never return stale data.

## Interface
Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 registers)
- DEPTH, 4, pending-write queue entries (power of two, ≥2)

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; clears all state immediately
- alu_valid  in  1  ALU result present this cycle
- alu_addr  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  writeback can accept an ALU result this cycle
- mem_valid  in  1  load result present this cycle
- mem_addr  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load result
- mem_ready  out  1  writeback can accept a load result this cycle
- reg_write  out  1  register-file write enable
- write_addr  out  ADDR_W  register-file write address
- write_data  out  DATA_W  register-file write data
- q1_addr, q2_addr  in  ADDR_W  forwarding lookup addresses
- q1_hit, q2_hit  out  1  lookup matches a pending or in-flight write
- q1_data, q2_data  out  DATA_W  youngest matching value (0 when no hit)
- busy  out  1  queue non-empty or reg_write high

## Operation
- Transfer on a port = valid & ready at posedge. A valid without ready is ignored; the producer holds its values.
- alu_ready = mem_ready = registered flag, 1 when free entries ≥ 2 after the current edge's enqueue/dequeue. Both ports can therefore always be accepted together.
- Enqueue order when both transfer on the same edge: the mem entry is written first (older instruction), then the alu entry. Tail advances by 0, 1 or 2 modulo DEPTH.
- Dequeue: on each posedge with count > 0, the head is popped into the write registers: reg_write←1, write_addr/write_data←head. With count = 0, reg_write←0 and write_addr/write_data hold their previous values.
- An entry enqueued on edge k can be dequeued on edge k+1 at the earliest. Enqueue and dequeue on the same edge are legal. Count is updated as count + enq − deq.
- Writes to the same address are never merged. Every accepted result is written, in acceptance order.
- Forwarding is combinational over the queue entries plus the write stage (reg_write=1). Search priority, youngest first: tail-1 … head, then the write stage. Same-cycle incoming alu/mem data is not searched.
- Pointers are ADDR bits of log2(DEPTH) and wrap modulo DEPTH. Full/empty is determined from count (log2(DEPTH)+1 bits).

## Timing
- Reset (async, low): count, head, tail ← 0; reg_write, write_addr, write_data ← 0; alu_ready, mem_ready ← 1; busy ← 0. The q*_hit outputs are 0 because no entries are valid. Pending writes are discarded, including mid-operation writes.
- Latency with an empty queue: input accepted at edge k → reg_write high during the cycle after edge k+1. The register file commits the value at edge k+2.
- Throughput: 1 write/cycle sustained. Two inputs per cycle are accepted only while ≥2 entries are free.
- After reset deassertion, the first accepting edge is the next posedge.

## Test plan
- Single ALU result: alu addr 3, data 0x1234 at edge 1 → reg_write=1, write_addr=3, write_data=0x1234 during cycle after edge 2; reg_write=0 the cycle after that.
- Simultaneous inputs: mem (5, 0xAAAA) + alu (5, 0xBBBB) on one edge → two consecutive writes to r5, 0xAAAA then 0xBBBB. While both are pending, q1_addr=5 returns hit with 0xBBBB.
- Backpressure: both ports valid every cycle from empty, DEPTH=4 → ready drops after 1–2 edges. No entry is lost or duplicated, writes drain in order, and ready returns when ≥2 entries are free.
- Forwarding from write stage: alu (2, 0x0F0F) accepted and dequeued, queue empty → q2_addr=2 gives hit with 0x0F0F while reg_write=1. After the write, q2_hit=0. Also verify that q1_addr=7 with nothing pending gives hit=0, data=0.
- Pointer wrap: a 12-result stream to addresses 0..7,0..3 with data=index → exactly 12 writes in order, correct data across three wraps.
- Reset mid-operation: 3 entries queued, reset pulsed low asynchronously between edges → reg_write=0, busy=0, ready=1 immediately. No stale write occurs after release.
